// File: rtl/cm_sqrt_pkg.sv
// Shared definitions for the multi-channel square-root unit: FSM state
// encodings, a ceiling-log2 helper for counter sizing and the BPC check.
package cm_sqrt_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Smallest r with 2**r >= value; used to size the iteration counter.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

  // Bits-per-cycle must be 1, 2 or 4 and divide the root width evenly,
  // otherwise the iteration count would not land on a whole cycle.
  function automatic bit bpc_legal(input int bpc, input int sw);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((sw % bpc) == 0);
  endfunction

endpackage

// File: rtl/cm_sqrt_step.sv
// One restoring digit-recurrence step of the integer square root: brings
// down two radicand bits, trial-subtracts {root,01} and appends one root bit.
module cm_sqrt_step #(
  parameter int SW = 16
) (
  input  logic [SW+1:0] rem_in,
  input  logic [SW-1:0] root_in,
  input  logic [1:0]    bits_in,
  output logic [SW+1:0] rem_out,
  output logic [SW-1:0] root_out
);

  logic [SW+3:0] t;
  logic [SW+3:0] trial;
  logic [SW+3:0] diff;
  logic [SW+3:0] rem_full;
  logic          ge;

  // The partial remainder never exceeds 2*root, so the top two bits of the
  // widened result and the root MSB before the shift are always zero.
  logic [2:0] unused_bits;
  assign unused_bits = {rem_full[SW+3:SW+2], root_in[SW-1]};

  // Trial subtraction done at full width so nothing wraps before the compare.
  always_comb begin
    t        = {rem_in, bits_in};
    trial    = {2'b00, root_in, 2'b01};
    diff     = t - trial;
    ge       = (t >= trial);
    rem_full = ge ? diff : t;
    rem_out  = rem_full[SW+1:0];
    root_out = {root_in[SW-2:0], ge};
  end

endmodule

// File: rtl/cm_sqrt_mc.sv
// Multi-channel handshaked integer square root. Resolves BPC root bits per
// clock with a chain of recurrence steps; the channel tag travels alongside.
module cm_sqrt_mc
  import cm_sqrt_pkg::*;
#(
  parameter int  DW    = 32,
  parameter int  CH_W  = 7,
  parameter int  BPC   = 1,
  parameter int  ROUND = 0,
  localparam int DWE   = DW + (DW % 2),
  localparam int SW    = DWE / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   din_i,
  input  logic [CH_W-1:0] din_ch_i,
  input  logic            din_valid_i,
  output logic            din_ready_o,
  output logic [SW-1:0]   sqrt_o,
  output logic [SW:0]     rem_o,
  output logic [CH_W-1:0] ch_o,
  output logic            dout_valid_o,
  input  logic            dout_ready_i,
  output logic            busy_o
);

  localparam int ITER = SW / BPC;
  localparam int CW   = (ITER > 1) ? clogb2(ITER) : 1;

  if (!bpc_legal(BPC, SW)) begin : g_bpc_check
    $error("cm_sqrt_mc: BPC must be 1, 2 or 4 and divide the root width");
  end

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [DWE-1:0]  opnd;
  logic [SW+1:0]   rem_q;
  logic [SW-1:0]   root_q;
  logic [CH_W-1:0] ch_q;
  logic            accept;

  logic [SW+1:0]   rem_c  [BPC+1];
  logic [SW-1:0]   root_c [BPC+1];
  logic [SW+1:0]   rem_fin;
  logic [SW-1:0]   root_fin;
  logic [SW-1:0]   sqrt_next;

  assign din_ready_o  = (state == ST_IDLE) || ((state == ST_DONE) && dout_ready_i);
  assign accept       = din_valid_i && din_ready_o;
  assign dout_valid_o = (state == ST_DONE);
  assign busy_o       = (state == ST_CALC) || (state == ST_DONE);

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  for (genvar g = 0; g < BPC; g++) begin : g_step
    cm_sqrt_step #(.SW(SW)) u_step (
      .rem_in  (rem_c[g]),
      .root_in (root_c[g]),
      .bits_in (opnd[DWE-1-2*g -: 2]),
      .rem_out (rem_c[g+1]),
      .root_out(root_c[g+1])
    );
  end

  assign rem_fin  = rem_c[BPC];
  assign root_fin = root_c[BPC];

  // Round-to-nearest bumps the root when the remainder exceeds it, but never
  // past the all-ones root; the remainder output stays the floor remainder.
  always_comb begin
    sqrt_next = root_fin;
    if ((ROUND != 0) && (rem_fin > {2'b00, root_fin}) && !(&root_fin))
      sqrt_next = root_fin + 1'b1;
  end

  // FSM, recurrence state and result registers; an accept in DONE chains
  // straight into the next calculation without visiting IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      opnd   <= '0;
      rem_q  <= '0;
      root_q <= '0;
      ch_q   <= '0;
      sqrt_o <= '0;
      rem_o  <= '0;
      ch_o   <= '0;
    end else begin
      if (accept) begin
        state  <= ST_CALC;
        cnt    <= CW'(ITER - 1);
        opnd   <= DWE'(din_i);
        rem_q  <= '0;
        root_q <= '0;
        ch_q   <= din_ch_i;
      end else begin
        case (state)
          ST_CALC: begin
            opnd   <= opnd << (2 * BPC);
            rem_q  <= rem_fin;
            root_q <= root_fin;
            cnt    <= cnt - 1'b1;
            if (cnt == '0) begin
              state  <= ST_DONE;
              sqrt_o <= sqrt_next;
              rem_o  <= rem_fin[SW:0];
              ch_o   <= ch_q;
            end
          end
          ST_DONE: begin
            if (dout_ready_i) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cm_sqrt_mc.sv
// Bench for cm_sqrt_mc: five configurations share one input stream
// (DW=32 with BPC 1/2/4 and both rounding modes, plus DW=17), checked
// against hand-computed vectors and a bitwise reference square root.
module tb_cm_sqrt_mc;

  localparam int NI = 5;

  typedef struct {
    logic [31:0] din;
    logic [6:0]  ch;
    logic [31:0] fl;
    logic [31:0] rm;
    logic [31:0] rn;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [6:0]  din_ch;
  logic        din_valid;
  logic        dout_ready;

  logic [31:0] sq_a   [NI];
  logic [31:0] rm_a   [NI];
  logic [6:0]  ch_a   [NI];
  logic        vld_a  [NI];
  logic        busy_a [NI];
  logic        rdy_a  [NI];

  int              iter_a [NI] = '{16, 8, 4, 4, 9};
  int              lat_a  [NI];
  longint unsigned exp_sq [NI];
  longint unsigned exp_rm [NI];
  logic [6:0]      exp_ch;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [14];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int B = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    localparam int R = ((gi == 1) || (gi == 3)) ? 1 : 0;
    logic [15:0] sq;
    logic [16:0] rm;
    logic [6:0]  c;
    logic        v, b, r;
    cm_sqrt_mc #(.DW(32), .CH_W(7), .BPC(B), .ROUND(R)) u_dut (
      .clk(clk), .rst(rst), .din_i(din), .din_ch_i(din_ch),
      .din_valid_i(din_valid), .din_ready_o(r), .sqrt_o(sq), .rem_o(rm),
      .ch_o(c), .dout_valid_o(v), .dout_ready_i(dout_ready), .busy_o(b)
    );
    assign sq_a[gi]   = 32'(sq);
    assign rm_a[gi]   = 32'(rm);
    assign ch_a[gi]   = c;
    assign vld_a[gi]  = v;
    assign busy_a[gi] = b;
    assign rdy_a[gi]  = r;
  end

  logic [8:0] sq17;
  logic [9:0] rm17;
  logic [6:0] c17;
  logic       v17, b17, r17;
  cm_sqrt_mc #(.DW(17), .CH_W(7), .BPC(1), .ROUND(0)) u_dut17 (
    .clk(clk), .rst(rst), .din_i(din[16:0]), .din_ch_i(din_ch),
    .din_valid_i(din_valid), .din_ready_o(r17), .sqrt_o(sq17), .rem_o(rm17),
    .ch_o(c17), .dout_valid_o(v17), .dout_ready_i(dout_ready), .busy_o(b17)
  );
  assign sq_a[4]   = 32'(sq17);
  assign rm_a[4]   = 32'(rm17);
  assign ch_a[4]   = c17;
  assign vld_a[4]  = v17;
  assign busy_a[4] = b17;
  assign rdy_a[4]  = r17;

  task automatic checkOutput(input string name, input longint unsigned act,
                             input longint unsigned expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  // Floor square root by setting root bits from the top while r*r stays <= x.
  function automatic void ref_sqrt(input longint unsigned x,
                                   output longint unsigned r,
                                   output longint unsigned m);
    r = 0;
    for (int b = 16; b >= 0; b--) begin
      longint unsigned c;
      c = r | (64'd1 << b);
      if (c * c <= x) r = c;
    end
    m = x - r * r;
  endfunction

  function automatic longint unsigned ref_round(input longint unsigned r,
                                                input longint unsigned m,
                                                input longint unsigned maxv);
    if ((m > r) && (r != maxv)) return r + 1;
    return r;
  endfunction

  task automatic set_exp_model(input logic [31:0] x, input logic [6:0] ch);
    longint unsigned r, m;
    ref_sqrt(64'(x), r, m);
    exp_sq[0] = r;
    exp_sq[1] = ref_round(r, m, 64'hFFFF);
    exp_sq[2] = r;
    exp_sq[3] = exp_sq[1];
    for (int i = 0; i < 4; i++) exp_rm[i] = m;
    ref_sqrt(64'(x[16:0]), r, m);
    exp_sq[4] = r;
    exp_rm[4] = m;
    exp_ch    = ch;
  endtask

  task automatic set_exp_vec(input vec_t v);
    longint unsigned r, m;
    exp_sq[0] = 64'(v.fl);
    exp_sq[1] = 64'(v.rn);
    exp_sq[2] = 64'(v.fl);
    exp_sq[3] = 64'(v.rn);
    for (int i = 0; i < 4; i++) exp_rm[i] = 64'(v.rm);
    ref_sqrt(64'(v.din[16:0]), r, m);
    exp_sq[4] = r;
    exp_rm[4] = m;
    exp_ch    = v.ch;
  endtask

  // Present one operand for a single cycle; all instances accept together.
  task automatic applyStimulus(input logic [31:0] x, input logic [6:0] ch);
    din       = x;
    din_ch    = ch;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  // Count edges after the accept edge until each instance raises valid.
  task automatic wait_results();
    for (int i = 0; i < NI; i++) lat_a[i] = -1;
    for (int c = 1; c <= 40; c++) begin
      bit all_seen;
      @(posedge clk);
      #1;
      all_seen = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (vld_a[i] && (lat_a[i] < 0)) lat_a[i] = c;
        if (lat_a[i] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
    end
  endtask

  task automatic verify_results(input string tag);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("%s.u%0d.latency", tag, i), 64'(lat_a[i]), 64'(iter_a[i]));
      checkOutput($sformatf("%s.u%0d.valid", tag, i), 64'(vld_a[i]), 64'd1);
      checkOutput($sformatf("%s.u%0d.sqrt", tag, i), 64'(sq_a[i]), exp_sq[i]);
      checkOutput($sformatf("%s.u%0d.rem", tag, i), 64'(rm_a[i]), exp_rm[i]);
      checkOutput($sformatf("%s.u%0d.ch", tag, i), 64'(ch_a[i]), 64'(exp_ch));
    end
  endtask

  task automatic release_outputs(input string tag);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("%s.u%0d.valid_drop", tag, i), 64'(vld_a[i]), 64'd0);
      checkOutput($sformatf("%s.u%0d.ready_idle", tag, i), 64'(rdy_a[i]), 64'd1);
    end
  endtask

  initial begin
    vecs[0]  = '{32'd144,         7'd5,   32'd12,     32'd0,       32'd12};
    vecs[1]  = '{32'd0,           7'd1,   32'd0,      32'd0,       32'd0};
    vecs[2]  = '{32'hFFFF_FFFF,   7'd127, 32'hFFFF,   32'h1_FFFE,  32'hFFFF};
    vecs[3]  = '{32'd30,          7'd2,   32'd5,      32'd5,       32'd5};
    vecs[4]  = '{32'd31,          7'd3,   32'd5,      32'd6,       32'd6};
    vecs[5]  = '{32'd1,           7'd4,   32'd1,      32'd0,       32'd1};
    vecs[6]  = '{32'd2,           7'd6,   32'd1,      32'd1,       32'd1};
    vecs[7]  = '{32'd3,           7'd7,   32'd1,      32'd2,       32'd2};
    vecs[8]  = '{32'd65536,       7'd8,   32'd256,    32'd0,       32'd256};
    vecs[9]  = '{32'd1000000,     7'd10,  32'd1000,   32'd0,       32'd1000};
    vecs[10] = '{32'd999999,      7'd9,   32'd999,    32'd1998,    32'd1000};
    vecs[11] = '{32'hFFFE_0001,   7'd11,  32'hFFFF,   32'd0,       32'hFFFF};
    vecs[12] = '{32'hFFFE_0000,   7'd12,  32'hFFFE,   32'h1_FFFC,  32'hFFFF};
    vecs[13] = '{32'h0001_FFFF,   7'd13,  32'd362,    32'd27,      32'd362};

    rst        = 1'b0;
    din        = '0;
    din_ch     = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #2 rst = 1'b1;
    #10;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("reset.u%0d.valid", i), 64'(vld_a[i]), 64'd0);
      checkOutput($sformatf("reset.u%0d.busy", i), 64'(busy_a[i]), 64'd0);
      checkOutput($sformatf("reset.u%0d.sqrt", i), 64'(sq_a[i]), 64'd0);
      checkOutput($sformatf("reset.u%0d.rem", i), 64'(rm_a[i]), 64'd0);
      checkOutput($sformatf("reset.u%0d.ch", i), 64'(ch_a[i]), 64'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      checkOutput($sformatf("post_reset.u%0d.ready", i), 64'(rdy_a[i]), 64'd1);

    // Directed table of hand-computed roots.
    for (int v = 0; v < 14; v++) begin
      set_exp_vec(vecs[v]);
      applyStimulus(vecs[v].din, vecs[v].ch);
      wait_results();
      verify_results($sformatf("vec%0d", v));
      release_outputs($sformatf("vec%0d", v));
    end

    // Back-pressure: result must hold still while downstream stalls.
    set_exp_vec(vecs[0]);
    applyStimulus(vecs[0].din, vecs[0].ch);
    wait_results();
    verify_results("bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d.valid", c), 64'(vld_a[0]), 64'd1);
      checkOutput($sformatf("bp_hold%0d.sqrt", c), 64'(sq_a[0]), 64'd12);
      checkOutput($sformatf("bp_hold%0d.rem", c), 64'(rm_a[0]), 64'd0);
      checkOutput($sformatf("bp_hold%0d.ch", c), 64'(ch_a[0]), 64'd5);
      checkOutput($sformatf("bp_hold%0d.din_ready", c), 64'(rdy_a[0]), 64'd0);
    end

    // Release and accept a new operand on the same edge.
    set_exp_vec(vecs[10]);
    dout_ready = 1'b1;
    applyStimulus(vecs[10].din, vecs[10].ch);
    dout_ready = 1'b0;
    checkOutput("chain.valid_drop", 64'(vld_a[0]), 64'd0);
    checkOutput("chain.busy", 64'(busy_a[0]), 64'd1);
    checkOutput("chain.din_ready", 64'(rdy_a[0]), 64'd0);
    wait_results();
    verify_results("chain");
    release_outputs("chain");

    // Reset in the middle of a calculation drops the operation.
    applyStimulus(32'hFFFF_FFFF, 7'd3);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("midrst.u%0d.valid", i), 64'(vld_a[i]), 64'd0);
      checkOutput($sformatf("midrst.u%0d.busy", i), 64'(busy_a[i]), 64'd0);
      checkOutput($sformatf("midrst.u%0d.sqrt", i), 64'(sq_a[i]), 64'd0);
      checkOutput($sformatf("midrst.u%0d.rem", i), 64'(rm_a[i]), 64'd0);
      checkOutput($sformatf("midrst.u%0d.ch", i), 64'(ch_a[i]), 64'd0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) if (vld_a[i] || !rdy_a[i]) seen++;
      end
      checkOutput("midrst.quiet_after", 64'(seen), 64'd0);
    end
    set_exp_vec(vecs[9]);
    applyStimulus(vecs[9].din, vecs[9].ch);
    wait_results();
    verify_results("after_rst");
    release_outputs("after_rst");

    // Random operands against the reference model.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] x;
      logic [6:0]  ch;
      x  = (n % 10 == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
      ch = 7'($urandom_range(0, 127));
      set_exp_model(x, ch);
      applyStimulus(x, ch);
      wait_results();
      verify_results($sformatf("rnd%0d", n));
      release_outputs($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
